// File: rtl/game_state_ctrl.sv
// Snake game master sequencer: IDLE/PLAY/WIN/LOSE state machine, button and
// target-eaten conditioning, and the stretched score increment request.
module game_state_ctrl #(
    parameter int unsigned STRETCH_CYCLES = 100000,
    parameter logic [3:0]  WIN_TENS       = 4'd1,
    parameter logic [3:0]  WIN_UNITS      = 4'd0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_START,
    input  logic       TARGET_ATE,
    input  logic       SNAKE_COLLISION,
    input  logic [3:0] SCORE_UNITS,
    input  logic [3:0] SCORE_TENS,
    output logic       SCORE_RESET,
    output logic       SCORE_INC,
    output logic [1:0] MASTER_STATE,
    output logic       GAME_ACTIVE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

    localparam logic [16:0] STRETCH_LOAD = 17'(STRETCH_CYCLES - 1);
    localparam logic [7:0]  WIN_SCORE    = {WIN_TENS, WIN_UNITS};

    state_t      state, state_next;
    logic        btn_meta, btn_sync, btn_prev, btn_pulse;
    logic        btn_armed;
    logic [1:0]  sync_warm;
    logic        ate_prev;
    logic        eat_pulse;
    logic        win_reached;
    logic [16:0] stretch_cnt;

    // The button only arms once the synchroniser has flushed its reset value
    // and seen the button released, so a press held through reset is ignored.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_prev  <= 1'b0;
            btn_pulse <= 1'b0;
            btn_armed <= 1'b0;
            sync_warm <= '0;
            ate_prev  <= 1'b0;
        end else begin
            btn_meta  <= BTN_START;
            btn_sync  <= btn_meta;
            btn_prev  <= btn_sync;
            sync_warm <= {sync_warm[0], 1'b1};
            if (sync_warm[1] && !btn_sync)
                btn_armed <= 1'b1;
            btn_pulse <= btn_sync & ~btn_prev & btn_armed;
            ate_prev  <= TARGET_ATE;
        end
    end

    assign eat_pulse   = TARGET_ATE & ~ate_prev;
    assign win_reached = {SCORE_TENS, SCORE_UNITS} >= WIN_SCORE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (btn_pulse) state_next = PLAY;
            PLAY: begin
                if (SNAKE_COLLISION)
                    state_next = LOSE;
                else if (win_reached)
                    state_next = WIN;
            end
            WIN:  if (btn_pulse) state_next = IDLE;
            LOSE: if (btn_pulse) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign MASTER_STATE = state;

    // SCORE_RESET covers every IDLE cycle plus the first PLAY cycle, so the
    // counter is guaranteed to read 00 when the game starts.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SCORE_RESET <= 1'b1;
            GAME_ACTIVE <= 1'b0;
            SCORE_INC   <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            SCORE_RESET <= (state == IDLE) || (state_next == IDLE);
            GAME_ACTIVE <= (state_next == PLAY);
            if (state_next != PLAY) begin
                stretch_cnt <= '0;
                SCORE_INC   <= 1'b0;
            end else if (stretch_cnt != '0) begin
                stretch_cnt <= stretch_cnt - 17'd1;
            end else if (SCORE_INC) begin
                SCORE_INC   <= 1'b0;
            end else if (eat_pulse && state == PLAY) begin
                stretch_cnt <= STRETCH_LOAD;
                SCORE_INC   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with short stretch and a second
// instance using a lowered winning score.
module tb_game_state_ctrl;

    localparam int unsigned STRETCH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn, ate, coll;
    logic [3:0] units, tens;
    logic       sr, inc, active;
    logic [1:0] mstate;
    logic       sr2, inc2, active2;
    logic [1:0] mstate2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(.STRETCH_CYCLES(STRETCH), .WIN_TENS(4'd1), .WIN_UNITS(4'd0)) dut (
        .CLK(clk), .RESET(rst), .BTN_START(btn), .TARGET_ATE(ate),
        .SNAKE_COLLISION(coll), .SCORE_UNITS(units), .SCORE_TENS(tens),
        .SCORE_RESET(sr), .SCORE_INC(inc), .MASTER_STATE(mstate), .GAME_ACTIVE(active)
    );

    game_state_ctrl #(.STRETCH_CYCLES(STRETCH), .WIN_TENS(4'd0), .WIN_UNITS(4'd3)) dut2 (
        .CLK(clk), .RESET(rst), .BTN_START(btn), .TARGET_ATE(ate),
        .SNAKE_COLLISION(coll), .SCORE_UNITS(units), .SCORE_TENS(tens),
        .SCORE_RESET(sr2), .SCORE_INC(inc2), .MASTER_STATE(mstate2), .GAME_ACTIVE(active2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure_pulse(input string tag, input bit second_rise);
        int high = 0;
        int rises = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ate = (i == 0) || (second_rise && i >= 4) || (!second_rise);
            step(1);
            if (inc && !prev) rises++;
            if (inc) high++;
            prev = inc;
        end
        ate = 1'b0;
        step(2);
        check({tag, "_rises"}, rises, 1);
        check({tag, "_width"}, high, STRETCH);
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; ate = 1'b0; coll = 1'b0; units = '0; tens = '0;
        step(2);
        check("rst_state", mstate, 2'b00);
        check("rst_sr", sr, 1'b1);
        check("rst_inc", inc, 1'b0);
        check("rst_active", active, 1'b0);
        rst = 1'b0;
        step(5);
        check("idle_state", mstate, 2'b00);
        check("idle_sr", sr, 1'b1);

        // Start: raw press sampled at edge 1, pulse after edge 3, PLAY after edge 4.
        btn = 1'b1;
        step(3);
        check("start_not_yet", mstate, 2'b00);
        step(1);
        check("start_play", mstate, 2'b01);
        check("start_active", active, 1'b1);
        check("start_sr_hold", sr, 1'b1);
        step(1);
        check("start_sr_drop", sr, 1'b0);
        btn = 1'b0;
        step(3);
        check("single_press", mstate, 2'b01);

        measure_pulse("held_ate", 1'b0);
        measure_pulse("retrigger", 1'b1);
        check("still_play", mstate, 2'b01);

        units = 4'd9;
        step(2);
        check("score09_play", mstate, 2'b01);
        units = 4'd0;

        // Collision and winning score together while the stretcher runs.
        ate = 1'b1;
        step(1);
        check("lose_inc_pre", inc, 1'b1);
        coll = 1'b1; tens = 4'd1; ate = 1'b0;
        step(1);
        check("lose_state", mstate, 2'b11);
        check("lose_inc_clr", inc, 1'b0);
        check("lose_active", active, 1'b0);
        check("lose_sr", sr, 1'b0);
        coll = 1'b0; tens = 4'd0;
        btn = 1'b1;
        step(4);
        check("lose_to_idle", mstate, 2'b00);
        check("lose_idle_sr", sr, 1'b1);
        btn = 1'b0;
        step(3);

        // Win path.
        btn = 1'b1;
        step(4);
        check("win_play", mstate, 2'b01);
        btn = 1'b0;
        step(2);
        tens = 4'd1;
        step(1);
        check("win_state", mstate, 2'b10);
        check("win_active", active, 1'b0);
        check("win_sr", sr, 1'b0);
        step(3);
        check("win_sr_hold", sr, 1'b0);
        tens = 4'd0;
        btn = 1'b1;
        step(4);
        check("win_to_idle", mstate, 2'b00);
        check("win_idle_sr", sr, 1'b1);
        btn = 1'b0;
        step(3);

        // Reset mid-stretch with the button held through it.
        btn = 1'b1;
        step(4);
        check("rr_play", mstate, 2'b01);
        step(2);
        ate = 1'b1;
        step(1);
        check("rr_inc_pre", inc, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rr_async_state", mstate, 2'b00);
        check("rr_async_sr", sr, 1'b1);
        check("rr_async_inc", inc, 1'b0);
        check("rr_async_active", active, 1'b0);
        step(1);
        rst = 1'b0; ate = 1'b0;
        step(10);
        check("rr_held_idle", mstate, 2'b00);
        btn = 1'b0;
        step(3);
        check("rr_release_idle", mstate, 2'b00);
        btn = 1'b1;
        step(4);
        check("rr_fresh_play", mstate, 2'b01);
        check("rr_fresh_play2", mstate2, 2'b01);
        btn = 1'b0;
        step(2);

        // Lowered winning score on the second instance.
        units = 4'd2;
        step(1);
        check("w03_at02", mstate2, 2'b01);
        units = 4'd3;
        step(1);
        check("w03_at03", mstate2, 2'b10);
        check("w10_at03", mstate, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
